// File: rtl/connect_ep_pkg.sv
// connect_ep_pkg
// Shared definitions for the CONNECT NoC user-port endpoints (receive and
// transmit side). Holds default field widths, bit-position helpers for the
// flit and credit words, and pack/unpack functions for the default layout.
//
// Flit word layout, MSB first: {valid, tail, dest, vc, data}
// Credit word layout, MSB first: {valid, vc}
package connect_ep_pkg;

  localparam int DEF_NUM_VCS         = 2;
  localparam int DEF_VC_BITS         = (DEF_NUM_VCS > 1) ? $clog2(DEF_NUM_VCS) : 1;
  localparam int DEF_FLIT_DATA_WIDTH = 32;
  localparam int DEF_DEST_BITS       = 4;
  localparam int DEF_BUF_DEPTH       = 8;

  // Bit positions as functions of the field widths so that modules with
  // non-default parameters derive the same layout.
  function automatic int vc_lsb(input int dw);
    return dw;
  endfunction

  function automatic int dest_lsb(input int dw, input int vb);
    return dw + vb;
  endfunction

  function automatic int tail_pos(input int dw, input int vb, input int db);
    return dw + vb + db;
  endfunction

  function automatic int valid_pos(input int dw, input int vb, input int db);
    return dw + vb + db + 1;
  endfunction

  function automatic int flit_width(input int dw, input int vb, input int db);
    return dw + vb + db + 2;
  endfunction

  localparam int DEF_FLIT_W   = flit_width(DEF_FLIT_DATA_WIDTH, DEF_VC_BITS, DEF_DEST_BITS);
  localparam int DEF_CREDIT_W = 1 + DEF_VC_BITS;

  typedef struct packed {
    logic                           valid;
    logic                           tail;
    logic [DEF_DEST_BITS-1:0]       dest;
    logic [DEF_VC_BITS-1:0]         vc;
    logic [DEF_FLIT_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef struct packed {
    logic                   valid;
    logic [DEF_VC_BITS-1:0] vc;
  } credit_t;

  function automatic logic [DEF_FLIT_W-1:0] pack_flit(
    input logic                           valid,
    input logic                           tail,
    input logic [DEF_DEST_BITS-1:0]       dest,
    input logic [DEF_VC_BITS-1:0]         vc,
    input logic [DEF_FLIT_DATA_WIDTH-1:0] data
  );
    return {valid, tail, dest, vc, data};
  endfunction

  function automatic flit_t unpack_flit(input logic [DEF_FLIT_W-1:0] word);
    return flit_t'(word);
  endfunction

  function automatic logic [DEF_CREDIT_W-1:0] pack_credit(
    input logic                   valid,
    input logic [DEF_VC_BITS-1:0] vc
  );
    return {valid, vc};
  endfunction

  function automatic credit_t unpack_credit(input logic [DEF_CREDIT_W-1:0] word);
    return credit_t'(word);
  endfunction

endpackage

// File: rtl/connect_vc_fifo.sv
// connect_vc_fifo
// Synchronous FIFO holding the flits of one virtual channel.
// A pop on empty is ignored; a push on full is ignored unless a pop happens
// in the same cycle, in which case both take effect and count is unchanged.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and entry
//   pop        : read request (advances the head)
//   dout       : current head entry, valid whenever empty=0
//   full, empty: occupancy flags
//   count      : occupancy, 0..DEPTH
module connect_vc_fifo #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Head is read combinationally so a flit written at one edge is visible
  // as the head in the very next cycle.
  assign dout = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/connect_rx_endpoint.sv
// connect_rx_endpoint
// Receive endpoint of a CONNECT NoC user port. Flits from the router output
// port are buffered per VC, arbitrated round robin at flit granularity and
// presented on a valid/ready stream. Each dequeued flit returns one credit
// on its VC the cycle after the handshake.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   my_id               : receive ID of this port (quasi-static)
//   flit_in             : {valid, tail, dest, vc, data} from the router
//   credit_out          : {valid, vc} credit back to the router
//   out_valid/out_ready : consumer handshake
//   out_data/tail/vc/dest : fields of the selected head flit (0 when idle)
//   pkt_count           : accepted tail flits, wrapping 16-bit counter
//   overflow_err        : sticky, flit arrived on a full VC and was dropped
//   misroute_err        : sticky, flit dest differed from my_id
//   err_clr             : synchronous clear of both sticky errors
module connect_rx_endpoint
  import connect_ep_pkg::*;
#(
  parameter int NUM_VCS         = DEF_NUM_VCS,
  parameter int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  parameter int FLIT_DATA_WIDTH = DEF_FLIT_DATA_WIDTH,
  parameter int DEST_BITS       = DEF_DEST_BITS,
  parameter int BUF_DEPTH       = DEF_BUF_DEPTH
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [DEST_BITS-1:0]                          my_id,
  input  logic [2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH-1:0] flit_in,
  output logic [VC_BITS:0]                              credit_out,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [FLIT_DATA_WIDTH-1:0]                    out_data,
  output logic                                          out_tail,
  output logic [VC_BITS-1:0]                            out_vc,
  output logic [DEST_BITS-1:0]                          out_dest,
  output logic [15:0]                                   pkt_count,
  output logic                                          overflow_err,
  output logic                                          misroute_err,
  input  logic                                          err_clr
);

  localparam int P_VC_LSB   = vc_lsb(FLIT_DATA_WIDTH);
  localparam int P_DEST_LSB = dest_lsb(FLIT_DATA_WIDTH, VC_BITS);
  localparam int P_TAIL     = tail_pos(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
  localparam int P_VALID    = valid_pos(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
  localparam int ENTRY_W    = 1 + DEST_BITS + FLIT_DATA_WIDTH;
  localparam int CNT_W      = $clog2(BUF_DEPTH) + 1;

  // Incoming flit fields
  logic                       w_in_valid;
  logic                       w_in_tail;
  logic [DEST_BITS-1:0]       w_in_dest;
  logic [VC_BITS-1:0]         w_in_vc;
  logic [FLIT_DATA_WIDTH-1:0] w_in_data;
  logic [ENTRY_W-1:0]         w_in_entry;

  assign w_in_valid = flit_in[P_VALID];
  assign w_in_tail  = flit_in[P_TAIL];
  assign w_in_dest  = flit_in[P_DEST_LSB +: DEST_BITS];
  assign w_in_vc    = flit_in[P_VC_LSB +: VC_BITS];
  assign w_in_data  = flit_in[FLIT_DATA_WIDTH-1:0];
  assign w_in_entry = {w_in_tail, w_in_dest, w_in_data};

  // Per-VC FIFO signals
  logic [NUM_VCS-1:0] w_push;
  logic [NUM_VCS-1:0] w_pop;
  logic [NUM_VCS-1:0] w_full;
  logic [NUM_VCS-1:0] w_empty;
  logic [NUM_VCS-1:0] w_nonempty;
  logic [NUM_VCS-1:0] w_acc_vc;
  logic [ENTRY_W-1:0] w_dout  [NUM_VCS];
  logic [CNT_W-1:0]   w_count [NUM_VCS];

  // Arbitration / output state
  logic [VC_BITS-1:0] r_last_grant;
  logic               r_hold_valid;
  logic [VC_BITS-1:0] r_hold_vc;
  logic               r_credit_valid;
  logic [VC_BITS-1:0] r_credit_vc;
  logic [15:0]        r_pkt_count;
  logic               r_overflow_err;
  logic               r_misroute_err;

  logic               w_rr_found;
  logic [VC_BITS-1:0] w_rr_idx;
  logic [VC_BITS-1:0] w_rr_vc;
  logic [VC_BITS-1:0] w_sel_vc;
  logic               w_out_valid;
  logic               w_handshake;
  logic [ENTRY_W-1:0] w_sel_entry;
  logic               w_accept;
  logic               w_ovf_evt;
  logic               w_mis_evt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VCS; gi++) begin : g_vc
      assign w_push[gi]     = w_in_valid && (w_in_vc == VC_BITS'(gi));
      assign w_pop[gi]      = w_handshake && (w_sel_vc == VC_BITS'(gi));
      assign w_nonempty[gi] = (w_count[gi] != '0);
      // Full is only a refusal if the same VC is not popped on this edge.
      assign w_acc_vc[gi]   = w_push[gi] && (!w_full[gi] || w_pop[gi]);

      connect_vc_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (BUF_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .din   (w_in_entry),
        .dout  (w_dout[gi]),
        .full  (w_full[gi]),
        .empty (w_empty[gi]),
        .count (w_count[gi])
      );
    end
  endgenerate

  // Round robin: first non-empty VC starting after the last granted one.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_vc    = '0;
    for (int k = 1; k <= NUM_VCS; k++) begin
      w_rr_idx = VC_BITS'((int'(r_last_grant) + k) % NUM_VCS);
      if (!w_rr_found && !w_empty[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_vc    = w_rr_idx;
      end
    end
  end

  // A presented flit that was not taken stays selected, so a newly filled
  // higher-priority VC cannot pre-empt it.
  assign w_sel_vc    = r_hold_valid ? r_hold_vc : w_rr_vc;
  assign w_out_valid = r_hold_valid || (|w_nonempty);
  assign w_handshake = w_out_valid && out_ready;
  assign w_sel_entry = w_dout[w_sel_vc];

  assign out_valid = w_out_valid;
  assign out_tail  = w_out_valid && w_sel_entry[ENTRY_W-1];
  assign out_dest  = w_out_valid ? w_sel_entry[FLIT_DATA_WIDTH +: DEST_BITS] : '0;
  assign out_data  = w_out_valid ? w_sel_entry[FLIT_DATA_WIDTH-1:0] : '0;
  assign out_vc    = w_out_valid ? w_sel_vc : '0;

  assign w_accept  = |w_acc_vc;
  assign w_ovf_evt = w_in_valid && !w_accept;
  assign w_mis_evt = w_in_valid && (w_in_dest != my_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant   <= VC_BITS'(NUM_VCS - 1);
      r_hold_valid   <= 1'b0;
      r_hold_vc      <= '0;
      r_credit_valid <= 1'b0;
      r_credit_vc    <= '0;
      r_pkt_count    <= '0;
      r_overflow_err <= 1'b0;
      r_misroute_err <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_last_grant <= w_sel_vc;
      end
      r_hold_valid   <= w_out_valid && !out_ready;
      r_hold_vc      <= w_sel_vc;
      r_credit_valid <= w_handshake;
      r_credit_vc    <= w_handshake ? w_sel_vc : '0;
      if (w_accept && w_in_tail) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      // A new error event in the clearing cycle keeps the flag set.
      r_overflow_err <= w_ovf_evt || (r_overflow_err && !err_clr);
      r_misroute_err <= w_mis_evt || (r_misroute_err && !err_clr);
    end
  end

  assign credit_out   = {r_credit_valid, r_credit_vc};
  assign pkt_count    = r_pkt_count;
  assign overflow_err = r_overflow_err;
  assign misroute_err = r_misroute_err;

endmodule

// File: tb/tb_connect_rx_endpoint.sv
module tb_connect_rx_endpoint;
  import connect_ep_pkg::*;

  localparam int NVC   = 2;
  localparam int DEPTH = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [3:0]               my_id;
  logic [DEF_FLIT_W-1:0]    flit_in;
  logic [DEF_CREDIT_W-1:0]  credit_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic                     out_tail;
  logic [0:0]               out_vc;
  logic [3:0]               out_dest;
  logic [15:0]              pkt_count;
  logic                     overflow_err;
  logic                     misroute_err;
  logic                     err_clr;

  always #5 clk = ~clk;

  connect_rx_endpoint #(
    .NUM_VCS         (NVC),
    .VC_BITS         (1),
    .FLIT_DATA_WIDTH (32),
    .DEST_BITS       (4),
    .BUF_DEPTH       (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .my_id        (my_id),
    .flit_in      (flit_in),
    .credit_out   (credit_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tail     (out_tail),
    .out_vc       (out_vc),
    .out_dest     (out_dest),
    .pkt_count    (pkt_count),
    .overflow_err (overflow_err),
    .misroute_err (misroute_err),
    .err_clr      (err_clr)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [0:0]  vc;
    logic        tail;
    logic [3:0]  dest;
    logic [31:0] data;
  } rec_t;

  // Reference model: per-VC queues plus the arbitration rules
  rec_t        mq [NVC][$];
  int          m_last;
  bit          m_held;
  int          m_held_vc;
  logic [15:0] m_pkt;
  bit          m_ovf;
  bit          m_mis;

  // Observed and expected logs
  rec_t obs_out[$], exp_out[$], obs_cr[$], exp_cr[$], obs_v[$], exp_v[$];

  int n_pass  = 0;
  int n_total = 0;
  int cycle_no = 0;

  function automatic int first_diff(input rec_t a[$], input rec_t b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic string rec_str(input rec_t q[$], input int i);
    if (i < 0 || i >= q.size()) return "none";
    return $sformatf("cyc=%0d vc=%0d tail=%0b dest=%0d data=%h",
                     q[i].cyc, q[i].vc, q[i].tail, q[i].dest, q[i].data);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NVC; v++) mq[v].delete();
    m_last = NVC - 1; m_held = 0; m_held_vc = 0;
    m_pkt = '0; m_ovf = 0; m_mis = 0;
  endtask

  task automatic clear_logs();
    obs_out.delete(); exp_out.delete(); obs_cr.delete();
    exp_cr.delete(); obs_v.delete(); exp_v.delete();
  endtask

  // One clock cycle: entered just after a posedge, drives inputs, logs what
  // the DUT shows and what the model predicts, then crosses the next edge.
  task automatic cyc(input logic v, input logic t, input logic [3:0] d,
                     input logic vcx, input logic [31:0] data,
                     input logic rdy, input logic clr);
    rec_t r, e;
    bit   ev, ovf_evt, mis_evt;
    int   sel, popped;
    flit_in = pack_flit(v, t, d, vcx, data);
    out_ready = rdy;
    err_clr = clr;
    #3;
    r = '0; r.cyc = cycle_no; r.data = {31'd0, out_valid};
    obs_v.push_back(r);
    if (out_valid && out_ready)
      obs_out.push_back('{cyc: cycle_no, vc: out_vc, tail: out_tail, dest: out_dest, data: out_data});
    if (credit_out[1]) begin
      r = '0; r.cyc = cycle_no; r.vc = credit_out[0];
      obs_cr.push_back(r);
    end
    ev = m_held;
    for (int k = 0; k < NVC; k++) if (mq[k].size() > 0) ev = 1;
    r = '0; r.cyc = cycle_no; r.data = {31'd0, ev};
    exp_v.push_back(r);
    sel = -1;
    if (m_held) sel = m_held_vc;
    else for (int k = 1; k <= NVC; k++)
      if (sel < 0 && mq[(m_last + k) % NVC].size() > 0) sel = (m_last + k) % NVC;
    popped = -1;
    if (ev && rdy) begin
      e = mq[sel].pop_front();
      e.cyc = cycle_no;
      exp_out.push_back(e);
      r = '0; r.cyc = cycle_no + 1; r.vc = 1'(sel);
      exp_cr.push_back(r);
      m_last = sel;
      popped = sel;
    end
    m_held = ev && !rdy;
    m_held_vc = sel;
    ovf_evt = 0; mis_evt = 0;
    if (v) begin
      if (mq[vcx].size() < DEPTH || popped == int'(vcx)) begin
        mq[vcx].push_back('{cyc: 0, vc: vcx, tail: t, dest: d, data: data});
        if (t) m_pkt++;
      end else ovf_evt = 1;
      if (d != my_id) mis_evt = 1;
    end
    m_ovf = ovf_evt || (m_ovf && !clr);
    m_mis = mis_evt || (m_mis && !clr);
    @(posedge clk); #1;
    cycle_no++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; flit_in = '0; out_ready = 0; err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    cycle_no++;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (out_valid !== 1'b0 || credit_out !== '0) $display("FAIL reset_out: out_valid=%b credit_out=%b, required 0 0", out_valid, credit_out);
    else n_pass++;
    n_total++;
    if (out_data !== '0 || out_tail !== 0 || out_vc !== 0 || out_dest !== 0)
      $display("FAIL reset_fields: data=%h tail=%b vc=%b dest=%h, required all 0", out_data, out_tail, out_vc, out_dest);
    else n_pass++;
    n_total++;
    if (pkt_count !== 16'd0 || overflow_err !== 0 || misroute_err !== 0)
      $display("FAIL reset_status: pkt=%0d ovf=%b mis=%b, required 0 0 0", pkt_count, overflow_err, misroute_err);
    else n_pass++;
  endtask

  task automatic test_single();
    int d;
    clear_logs();
    cyc(1, 1, 4'd10, 0, 32'h000dead0, 1, 0);
    idle(3, 1);
    n_total++;
    if (obs_out.size() == 1 && obs_out[0].data === 32'h000dead0) n_pass++;
    else $display("FAIL single_data: got %s, required data=000dead0", rec_str(obs_out, 0));
    n_total++; d = first_diff(obs_out, exp_out);
    if (d < 0) n_pass++; else $display("FAIL single_stream: rec %0d got %s required %s", d, rec_str(obs_out, d), rec_str(exp_out, d));
    n_total++; d = first_diff(obs_cr, exp_cr);
    if (d < 0) n_pass++; else $display("FAIL single_credit: rec %0d got %s required %s", d, rec_str(obs_cr, d), rec_str(exp_cr, d));
    n_total++; d = first_diff(obs_v, exp_v);
    if (d < 0) n_pass++; else $display("FAIL single_valid: rec %0d got %s required %s", d, rec_str(obs_v, d), rec_str(exp_v, d));
    n_total++;
    if (pkt_count === 16'd1 && overflow_err === 0 && misroute_err === 0) n_pass++;
    else $display("FAIL single_status: pkt=%0d ovf=%b mis=%b, required 1 0 0", pkt_count, overflow_err, misroute_err);
  endtask

  task automatic test_overflow();
    int d;
    clear_logs();
    for (int i = 0; i < 9; i++) cyc(1, 1, 4'd10, 0, 32'(i), 0, 0);
    idle(1, 0);
    n_total++;
    if (overflow_err === 1'b1 && obs_cr.size() == 0) n_pass++;
    else $display("FAIL ovf_flag: ovf=%b credits=%0d, required 1 0", overflow_err, obs_cr.size());
    n_total++;
    if (pkt_count === m_pkt) n_pass++;
    else $display("FAIL ovf_pkt: pkt=%0d required %0d", pkt_count, m_pkt);
    idle(12, 1);
    n_total++;
    if (obs_out.size() == 8 && obs_cr.size() == 8) n_pass++;
    else $display("FAIL ovf_counts: out=%0d credits=%0d, required 8 8", obs_out.size(), obs_cr.size());
    n_total++; d = first_diff(obs_out, exp_out);
    if (d < 0) n_pass++; else $display("FAIL ovf_stream: rec %0d got %s required %s", d, rec_str(obs_out, d), rec_str(exp_out, d));
    n_total++; d = first_diff(obs_cr, exp_cr);
    if (d < 0) n_pass++; else $display("FAIL ovf_credit: rec %0d got %s required %s", d, rec_str(obs_cr, d), rec_str(exp_cr, d));
    cyc(0, 0, 0, 0, 0, 1, 1);
    n_total++;
    if (overflow_err === 1'b0) n_pass++;
    else $display("FAIL ovf_clear: ovf=%b required 0", overflow_err);
  endtask

  task automatic test_round_robin();
    int d;
    logic [3:0] order;
    clear_logs();
    cyc(1, 0, 4'd10, 0, 32'hA0, 0, 0);
    cyc(1, 1, 4'd10, 0, 32'hA1, 0, 0);
    cyc(1, 0, 4'd10, 1, 32'hB0, 0, 0);
    cyc(1, 1, 4'd10, 1, 32'hB1, 0, 0);
    idle(7, 1);
    order = '1;
    for (int i = 0; i < 4 && i < obs_out.size(); i++) order[3-i] = obs_out[i].vc[0];
    n_total++;
    if (obs_out.size() == 4 && order === 4'b0101) n_pass++;
    else $display("FAIL rr_order: vc order %b (%0d flits), required 0101 (4 flits)", order, obs_out.size());
    n_total++; d = first_diff(obs_out, exp_out);
    if (d < 0) n_pass++; else $display("FAIL rr_stream: rec %0d got %s required %s", d, rec_str(obs_out, d), rec_str(exp_out, d));
    n_total++; d = first_diff(obs_cr, exp_cr);
    if (d < 0) n_pass++; else $display("FAIL rr_credit: rec %0d got %s required %s", d, rec_str(obs_cr, d), rec_str(exp_cr, d));
  endtask

  task automatic test_misroute();
    int d;
    clear_logs();
    cyc(1, 1, 4'd3, 1, 32'h1234, 1, 0);
    idle(3, 1);
    n_total++;
    if (misroute_err === 1'b1) n_pass++;
    else $display("FAIL mis_flag: mis=%b required 1", misroute_err);
    n_total++; d = first_diff(obs_out, exp_out);
    if (d < 0 && obs_out.size() == 1) n_pass++; else $display("FAIL mis_stream: rec %0d got %s required %s", d, rec_str(obs_out, d), rec_str(exp_out, d));
    n_total++; d = first_diff(obs_cr, exp_cr);
    if (d < 0 && obs_cr.size() == 1) n_pass++; else $display("FAIL mis_credit: rec %0d got %s required %s", d, rec_str(obs_cr, d), rec_str(exp_cr, d));
    cyc(0, 0, 0, 0, 0, 1, 1);
    n_total++;
    if (misroute_err === 1'b0) n_pass++;
    else $display("FAIL mis_clear: mis=%b required 0", misroute_err);
    cyc(1, 0, 4'd5, 0, 32'h55, 1, 1);
    n_total++;
    if (misroute_err === 1'b1) n_pass++;
    else $display("FAIL mis_clear_vs_event: mis=%b required 1", misroute_err);
    idle(3, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_simultaneous();
    int d;
    clear_logs();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 4'd10, 0, 32'h100 + 32'(i), 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 4'd10, 0, 32'h200 + 32'(i), 1, 0);
    idle(16, 1);
    n_total++;
    if (overflow_err === 1'b0 && obs_out.size() == DEPTH + 6) n_pass++;
    else $display("FAIL simul_noovf: ovf=%b flits=%0d, required 0 %0d", overflow_err, obs_out.size(), DEPTH + 6);
    n_total++; d = first_diff(obs_out, exp_out);
    if (d < 0) n_pass++; else $display("FAIL simul_stream: rec %0d got %s required %s", d, rec_str(obs_out, d), rec_str(exp_out, d));
    n_total++; d = first_diff(obs_cr, exp_cr);
    if (d < 0) n_pass++; else $display("FAIL simul_credit: rec %0d got %s required %s", d, rec_str(obs_cr, d), rec_str(exp_cr, d));
  endtask

  task automatic test_random();
    int d;
    clear_logs();
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 1),
          ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd10,
          $urandom_range(0, 1), $urandom,
          $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 40 : 85),
          $urandom_range(0, 29) == 0);
    idle(20, 1);
    n_total++; d = first_diff(obs_out, exp_out);
    if (d < 0) n_pass++; else $display("FAIL rand_stream: rec %0d got %s required %s", d, rec_str(obs_out, d), rec_str(exp_out, d));
    n_total++; d = first_diff(obs_cr, exp_cr);
    if (d < 0) n_pass++; else $display("FAIL rand_credit: rec %0d got %s required %s", d, rec_str(obs_cr, d), rec_str(exp_cr, d));
    n_total++; d = first_diff(obs_v, exp_v);
    if (d < 0) n_pass++; else $display("FAIL rand_valid: rec %0d got %s required %s", d, rec_str(obs_v, d), rec_str(exp_v, d));
    n_total++;
    if (pkt_count === m_pkt && overflow_err === m_ovf && misroute_err === m_mis) n_pass++;
    else $display("FAIL rand_status: pkt=%0d ovf=%b mis=%b, required %0d %b %b",
                  pkt_count, overflow_err, misroute_err, m_pkt, m_ovf, m_mis);
  endtask

  task automatic test_async_reset();
    int d;
    clear_logs();
    cyc(1, 1, 4'd10, 0, 32'h301, 0, 0);
    cyc(1, 1, 4'd10, 1, 32'h302, 0, 0);
    cyc(1, 1, 4'd10, 0, 32'h303, 0, 0);
    cyc(1, 1, 4'd10, 1, 32'h304, 1, 0);
    flit_in = '0; out_ready = 0;
    n_total++;
    if (credit_out[1] === 1'b1 && out_valid === 1'b1 && pkt_count !== 16'd0) n_pass++;
    else $display("FAIL areset_pre: credit=%b valid=%b pkt=%0d, required credit=1x valid=1 pkt>0", credit_out, out_valid, pkt_count);
    #1 rst_n = 0;
    #1;
    n_total++;
    if (out_valid === 1'b0 && credit_out === '0) n_pass++;
    else $display("FAIL areset_out: valid=%b credit=%b, required 0 00", out_valid, credit_out);
    n_total++;
    if (pkt_count === 16'd0 && overflow_err === 0 && misroute_err === 0) n_pass++;
    else $display("FAIL areset_status: pkt=%0d ovf=%b mis=%b, required 0 0 0", pkt_count, overflow_err, misroute_err);
    model_reset();
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    cycle_no += 2;
    clear_logs();
    idle(5, 1);
    n_total++;
    if (obs_cr.size() == 0 && first_diff(obs_v, exp_v) < 0) n_pass++;
    else $display("FAIL areset_stale: credits=%0d valid diff at %0d, required 0 and none", obs_cr.size(), first_diff(obs_v, exp_v));
  endtask

  initial begin
    rst_n = 0;
    my_id = 4'd10;
    flit_in = '0;
    out_ready = 0;
    err_clr = 0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_misroute();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/connect_rx_endpoint.md
# connect_rx_endpoint

Receive-side endpoint for a CONNECT NoC user port: accepts flits from the router's output port into per-VC buffers and presents them to the local consumer through a valid/ready stream. It returns one credit per dequeued flit on the matching VC, so the router's credit counters stay exact. It is the sink counterpart of the traffic-generating PE and sits between the router output port and the local core.

## Interface
Parameters:
- NUM_VCS, 2: virtual channels.
- VC_BITS, (NUM_VCS>1 ? $clog2(NUM_VCS) : 1): VC field width.
- FLIT_DATA_WIDTH, 32: payload width.
- DEST_BITS, 4: destination field width.
- BUF_DEPTH, 8: flits per VC buffer, power of two, at least 2; equals the router's initial credit count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- my_id  in  DEST_BITS  this port's receive ID, quasi-static.
- flit_in  in  2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH  {valid, tail, dest, vc, data}, MSB first.
- credit_out  out  1+VC_BITS  {valid, vc}.
- out_valid  out  1  head flit available.
- out_ready  in  1  consumer accepts.
- out_data  out  FLIT_DATA_WIDTH  head flit payload.
- out_tail  out  1  head flit tail bit.
- out_vc  out  VC_BITS  VC of head flit.
- out_dest  out  DEST_BITS  dest field of head flit.
- pkt_count  out  16  tail flits received, wraps from 0xFFFF to 0.
- overflow_err  out  1  sticky: flit arrived on a full VC.
- misroute_err  out  1  sticky: flit dest != my_id.
- err_clr  in  1  synchronous clear of both sticky errors.

## Operation
- Enqueue: when flit_in valid=1 at a posedge, {tail, dest, data} is written into the FIFO of flit_in.vc.
- Full check: the write is refused only if that FIFO holds BUF_DEPTH entries and is not dequeued in the same cycle. On refusal the flit is dropped, overflow_err is set, no credit is returned for it, and the buffer is unchanged.
- Misroute: dest != my_id sets misroute_err. The flit is still buffered and credited.
- pkt_count increments on every accepted flit with tail=1. Dropped flits are not counted.
- Arbitration is flit-level round robin over non-empty VCs. The search starts at (last_grant+1) mod NUM_VCS, and last_grant updates only on a handshake. The output fields show the selected FIFO head.
- Handshake: a transfer occurs when out_valid && out_ready at a posedge. The granted FIFO pops. credit_out={1, granted vc} is driven the following cycle for exactly one cycle; otherwise credit_out=0.
- out_valid never deasserts without a handshake unless reset occurs. The selected VC holds while out_valid=1 and out_ready=0.
- err_clr clears the errors. An error event in the same cycle wins, so the flag stays 1.
- Reset values: all FIFOs empty, last_grant=NUM_VCS-1 (so VC0 is searched first), out_valid=0, out_data/out_tail/out_vc/out_dest=0, credit_out=0, pkt_count=0, both errors 0.
- Reset mid-operation: buffered flits and any pending credit are discarded immediately. The router must also be reset.

## Timing
- Flit accepted at edge N: out_valid=1 from edge N, i.e. visible in cycle N+1, provided no other VC is granted. Output fields are driven combinationally from registered FIFO state.
- Handshake at edge M: credit_out valid during cycle M+1. At most one credit per cycle.
- Back-to-back handshakes are possible every cycle at full throughput.
- Simultaneous enqueue and dequeue on the same VC: both take effect, and the count is unchanged.
- Pointer arithmetic is modulo BUF_DEPTH with log2(BUF_DEPTH) bits. Occupancy counters are log2(BUF_DEPTH)+1 bits.

## Structure
- Shared package connect_ep_pkg holds:
  - field-width localparams derived from NUM_VCS, DEST_BITS and FLIT_DATA_WIDTH;
  - bit-position constants for valid/tail/dest/vc/data;
  - pack/unpack functions for flit and credit words.
- The transmit PE uses the same package.
- Sub-module connect_vc_fifo: synchronous FIFO, one instance per VC.
  - Ports: push, pop, din, dout, full, empty, count.
  - Pop on empty and push on full without pop are ignored inside the FIFO, and the top level flags them.

## Test plan
- Reset, then with my_id=10 send one flit {v=1, t=1, dest=10, vc=0, data=0xdead0}, holding out_ready=1. Required: out_valid the next cycle with data 0xdead0; credit_out={1,0} the cycle after the handshake; pkt_count=1; no errors.
- With out_ready=0, send 8 flits on VC0, then a 9th. Required: 9th dropped; overflow_err=1; no credit emitted. After raising out_ready: exactly 8 flits out in order 0..7, 8 credits for vc0, one per cycle.
- With out_ready=0, load 2 flits on VC0 and 2 on VC1, then release. Required output order: VC0, VC1, VC0, VC1; credits in matching order.
- With out_ready=1, send dest=3 while my_id=10. Required: misroute_err=1; flit still delivered and credited. Then err_clr=1 for one cycle: misroute_err=0.
- With VC0 full, hold out_ready=1 and push a new VC0 flit on the edge a pop occurs. Required: no overflow; count stays 8; FIFO order preserved.
- Drive rst_n low asynchronously while 3 flits are buffered and a credit is pending. Required: out_valid=0, credit_out=0 and pkt_count=0 immediately, with no stale credit after reset release.
